pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have the parameter PC_W, default 10, giving the program-counter width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 8, giving the number of return-address stack entries (power of 2).
REQ-003 The block SHALL have the parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have the port stall, input, 1 bit: when 1, hold all state.
REQ-007 The block SHALL have the port PCSrc, input, 1 bit: take the branch/call target.
REQ-008 The block SHALL have the port Push, input, 1 bit: push the return address (call).
REQ-009 The block SHALL have the port Pop, input, 1 bit: pop the return address into the PC (return).
REQ-010 The block SHALL have the port target, input, PC_W bits: the jump/call destination.
REQ-011 The block SHALL have the port pc, output, PC_W bits: the registered current PC, fed to instruction fetch.
REQ-012 The block SHALL have the port depth, output, clog2(DEPTH)+1 bits: the registered stack occupancy.
REQ-013 The block SHALL have the ports stack_full and stack_empty, outputs, 1 bit each: combinational decodes of depth.
REQ-014 The block SHALL have the ports overflow and underflow, outputs, 1 bit each: sticky error flags, registered.

Function
REQ-015 Every state change SHALL occur one clk edge after the qualifying inputs; pc, depth and the flags SHALL all be registered.
REQ-016 When stall=1, pc, depth, the stack contents and the flags SHALL hold; PCSrc, Push and Pop SHALL be ignored.
REQ-017 Next-PC priority SHALL be, in order: Pop (pc <= top entry) > PCSrc (pc <= target) > sequential (pc <= pc+1).
REQ-018 PC arithmetic SHALL be modulo 2^PC_W: pc+1 from all-ones SHALL wrap to 0 with no flag.
REQ-019 On Push with the stack not full, the stack SHALL write pc+1 (wrapped) at index depth and increment depth.
REQ-020 Push with PCSrc=0 SHALL still push pc+1, and pc SHALL advance sequentially.
REQ-021 On Push with the stack full, the write SHALL be discarded, depth SHALL be unchanged, overflow SHALL set, and the PC update SHALL proceed per REQ-017.
REQ-022 On Pop with the stack not empty, pc SHALL load entry depth-1 and depth SHALL decrement.
REQ-023 On Pop with the stack empty, underflow SHALL set, depth SHALL stay 0, and pc SHALL take PCSrc/sequential per REQ-017 with Pop excluded.
REQ-024 When Push and Pop are both asserted, Pop SHALL take effect, Push SHALL be discarded, and no flag SHALL be raised for the discarded push.
REQ-025 overflow and underflow SHALL remain set until reset.
REQ-026 stack_full SHALL equal (depth==DEPTH) and stack_empty SHALL equal (depth==0).

Reset
REQ-027 When reset=0 at a clk edge, pc SHALL load RESET_PC, depth SHALL load 0, and overflow and underflow SHALL load 0, overriding stall and all other inputs.
REQ-028 Stack storage SHALL not be reset; its contents are don't-care, never observable while empty.
REQ-029 A reset asserted mid-call-sequence SHALL discard all pending entries; the first cycle after release SHALL fetch RESET_PC.

Structure
REQ-030 The default PC_W, DEPTH and RESET_PC values SHALL be constants in the shared processor package used by controlunit and datapath.
REQ-031 The storage and pointer SHALL be one sub-module, lifo_stack (push/pop/wdata/rdata/count/full/empty); next-PC selection and the flags SHALL live in pc_stack_unit.

Verification
REQ-032 The bench SHALL cover reset: reset=0 for 2 cycles, then release with idle inputs -> pc sequence 0,1,2,3; depth=0; flags=0.
REQ-033 The bench SHALL cover call and return: at pc=5, PCSrc=1, Push=1, target=0x100 -> pc=0x100, depth=1; 3 cycles later Pop=1 -> pc=6, depth=0.
REQ-034 The bench SHALL cover overflow: 9 consecutive calls from pc=0x10 with target=0x20 -> depth saturates at 8, stack_full=1, overflow=1, and 8 pops return pc 0x21,0x21,...,0x11 in LIFO order.
REQ-035 The bench SHALL cover underflow and wrap: Pop=1 at pc=0x3FF with the stack empty -> pc=0x000, underflow=1, depth=0.
REQ-036 The bench SHALL cover stall and simultaneous events: stall=1 with Push=1, Pop=1 -> no change; then depth=2 and Push=Pop=1 -> pc=top entry, depth=1, overflow=0.
REQ-037 The bench SHALL cover mid-sequence reset: depth=3, reset=0 for 1 cycle -> pc=RESET_PC, depth=0, stack_empty=1, flags cleared.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
// Shared processor constants for the PC / return-address stack unit,
// plus the next-PC source encoding used by the selection logic.
package pc_stack_unit_pkg;

  localparam int PC_W_DEF     = 10;
  localparam int DEPTH_DEF    = 8;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_TARGET = 2'd1,
    PC_RETURN = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_stack_unit_lifo_stack.sv
// Return-address LIFO: storage array plus occupancy counter.
// Pop wins over push when both are requested; a push while full is dropped.
// Storage is never reset, only the counter, so stale entries are unreachable.
module lifo_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_idx, top_idx;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pop & ~full;
  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign rdata   = mem[top_idx];
  assign count   = count_q;

  // Next occupancy: pop has priority, overflowing pushes leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end else if (do_push) begin
      count_d = count_q + (AW + 1)'(1);
    end
  end

  // Occupancy register, cleared by reset which empties the stack logically.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage, written at the current occupancy index on an accepted push.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack for call/return.
// Next-PC priority: return (non-empty pop) > branch target > pc+1.
// Overflow/underflow are sticky until reset; stall freezes everything.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    PCSrc,
  input  logic                    Push,
  input  logic                    Pop,
  input  logic [PC_W-1:0]         target,
  output logic [PC_W-1:0]         pc,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    overflow,
  output logic                    underflow
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  pc_sel_e         pc_sel;

  assign pc_inc   = pc_q + PC_W'(1);
  assign stk_push = Push & ~stall;
  assign stk_pop  = Pop & ~stall;

  lifo_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .wdata (pc_inc),
    .rdata (ret_addr),
    .count (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Choose the next-PC source; a pop on an empty stack falls through.
  always_comb begin
    pc_sel = PC_SEQ;
    if (Pop && !stk_empty) begin
      pc_sel = PC_RETURN;
    end else if (PCSrc) begin
      pc_sel = PC_TARGET;
    end
  end

  // Next PC and sticky error flags, all held while stalled.
  always_comb begin
    pc_d        = pc_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!stall) begin
      case (pc_sel)
        PC_RETURN: pc_d = ret_addr;
        PC_TARGET: pc_d = target;
        default:   pc_d = pc_inc;
      endcase
      if (Push && !Pop && stk_full) begin
        overflow_d = 1'b1;
      end
      if (Pop && stk_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // PC and flag registers; reset overrides stall and every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= PC_W'(RESET_PC);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc          = pc_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign stack_full  = stk_full;
  assign stack_empty = stk_empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a queue-based behavioural model of the PC and return stack.
module tb_pc_stack_unit;

  localparam int PC_W     = 10;
  localparam int DEPTH    = 8;
  localparam int RESET_PC = 0;
  localparam int PC_MASK  = (1 << PC_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   stall;
  logic                   pcSrc;
  logic                   push;
  logic                   pop;
  logic [PC_W-1:0]        target;
  logic [PC_W-1:0]        pc;
  logic [$clog2(DEPTH):0] depth;
  logic                   stackFull;
  logic                   stackEmpty;
  logic                   overflow;
  logic                   underflow;

  int total = 0;
  int bad   = 0;

  int mPc;
  int mStack[$];
  bit mOver;
  bit mUnder;
  bit modelValid = 1'b0;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PCSrc       (pcSrc),
    .Push        (push),
    .Pop         (pop),
    .target      (target),
    .pc          (pc),
    .depth       (depth),
    .stack_full  (stackFull),
    .stack_empty (stackEmpty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a queue holds return addresses, top at the back.
  always @(posedge clk) begin
    int nextPc;
    if (!reset) begin
      mPc = RESET_PC;
      mStack.delete();
      mOver = 1'b0;
      mUnder = 1'b0;
    end else if (!stall) begin
      nextPc = pcSrc ? int'(target) : ((mPc + 1) & PC_MASK);
      if (pop) begin
        if (mStack.size() > 0) nextPc = mStack.pop_back();
        else mUnder = 1'b1;
      end else if (push) begin
        if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) & PC_MASK);
        else mOver = 1'b1;
      end
      mPc = nextPc;
    end
    modelValid = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("pc", 32'(pc), mPc);
      checkOutput("depth", 32'(depth), mStack.size());
      checkOutput("stack_full", 32'(stackFull), 32'(mStack.size() == DEPTH));
      checkOutput("stack_empty", 32'(stackEmpty), 32'(mStack.size() == 0));
      checkOutput("overflow", 32'(overflow), 32'(mOver));
      checkOutput("underflow", 32'(underflow), 32'(mUnder));
    end
  end

  task automatic applyStimulus(input bit rst, input bit st, input bit pcs,
                               input bit pu, input bit po, input int tg);
    reset  = rst;
    stall  = st;
    pcSrc  = pcs;
    push   = pu;
    pop    = po;
    target = tg[PC_W-1:0];
    @(negedge clk);
  endtask

  task automatic expectState(input string tag, input int ePc, input int eDepth,
                             input bit eOver, input bit eUnder);
    checkOutput({tag, " pc"}, 32'(pc), ePc);
    checkOutput({tag, " depth"}, 32'(depth), eDepth);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(eOver));
    checkOutput({tag, " underflow"}, 32'(underflow), 32'(eUnder));
    checkOutput({tag, " model pc"}, mPc, ePc);
  endtask

  initial begin
    reset  = 1'b0;
    stall  = 1'b0;
    pcSrc  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    target = '0;

    // Reset for two cycles, then sequential fetch 1,2,3.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectState("reset", 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      expectState("seq", i, 0, 0, 0);
    end

    // Call from pc=5 to 0x100 and return to 6.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    expectState("pre-call", 5, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 'h100);
    expectState("call", 'h100, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    expectState("in-call", 'h103, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    expectState("return", 6, 0, 0, 0);

    // Nine calls from 0x10 to 0x20: the ninth overflows.
    applyStimulus(1, 0, 1, 0, 0, 'h10);
    expectState("jump", 'h10, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, 1, 0, 'h20);
    expectState("overflow", 'h20, 8, 1, 0);
    checkOutput("full literal", 32'(stackFull), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0);
      expectState("lifo pop", (i < 7) ? 'h21 : 'h11, 7 - i, 1, 0);
    end
    checkOutput("empty literal", 32'(stackEmpty), 1);

    // Underflowing pop at 0x3FF wraps to 0.
    applyStimulus(1, 0, 1, 0, 0, 'h3FF);
    expectState("at 3ff", 'h3FF, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    expectState("underflow wrap", 0, 0, 1, 1);

    // Reset mid call sequence with three pending entries.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 0, 'h50);
    expectState("depth3", 'h50, 3, 1, 1);
    applyStimulus(0, 1, 1, 1, 0, 'h77);
    expectState("mid reset", RESET_PC, 0, 0, 0);
    checkOutput("empty after reset", 32'(stackEmpty), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    expectState("post reset", 1, 0, 0, 0);

    // Stall blocks everything, then simultaneous push+pop behaves as pop.
    applyStimulus(1, 0, 1, 1, 0, 'h40);
    applyStimulus(1, 0, 1, 1, 0, 'h80);
    expectState("two calls", 'h80, 2, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 'h3);
    expectState("stall", 'h80, 2, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    expectState("push+pop", 'h41, 1, 0, 0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(63) != 0, $urandom_range(7) == 0,
                    $urandom_range(3) == 0, $urandom_range(2) == 0,
                    $urandom_range(3) == 0, int'($urandom_range(PC_MASK)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
